// File: rtl/mem_reg_bank_pkg.sv
// mem_regs_pkg: register-bank access modes, byte-lane count and mode decode from RO/PULSE masks
package mem_regs_pkg;
  typedef enum logic [1:0] {REG_RW, REG_RO, REG_PULSE} reg_mode_e;
  function automatic int reg_bytes(input int width);
    return (width + 7) / 8;
  endfunction
  function automatic reg_mode_e reg_mode(input logic ro, input logic pulse);
    return ro ? REG_RO : pulse ? REG_PULSE : REG_RW;
  endfunction
endpackage

// File: rtl/mem_reg_bank_if.sv
// mem_reg_bank_if: memory-style bus (write select/addr/data/strobe, read select/addr/strobe, registered read data/valid/errors); master = AXI4-Lite slave side, slave = register bank
interface mem_reg_bank_if #(
  parameter int REGISTER_N = 16,
  parameter int REG_DATA_WIDTH = 32,
  parameter int ADDR_W = (REGISTER_N > 1) ? $clog2(REGISTER_N) : 1
);
  import mem_regs_pkg::*;
  localparam int BL = reg_bytes(REG_DATA_WIDTH);
  logic mem_wrSelect;
  logic [ADDR_W-1:0] mem_wrAddr;
  logic [REG_DATA_WIDTH-1:0] mem_wrdin;
  logic [BL-1:0] mem_wrByteStrobe;
  logic mem_rdSelect;
  logic [ADDR_W-1:0] mem_rdAddr;
  logic mem_rdStrobe;
  logic [REG_DATA_WIDTH-1:0] mem_rddout;
  logic mem_rdValid;
  logic mem_rdErr;
  logic mem_wrErr;
  modport master (
    output mem_wrSelect, mem_wrAddr, mem_wrdin, mem_wrByteStrobe, mem_rdSelect, mem_rdAddr, mem_rdStrobe,
    input mem_rddout, mem_rdValid, mem_rdErr, mem_wrErr
  );
  modport slave (
    input mem_wrSelect, mem_wrAddr, mem_wrdin, mem_wrByteStrobe, mem_rdSelect, mem_rdAddr, mem_rdStrobe,
    output mem_rddout, mem_rdValid, mem_rdErr, mem_wrErr
  );
endinterface

// File: rtl/mem_reg_bank_cell.sv
// mem_reg_cell: one register (clk, rst, qualified bus write + byte enables, hw load, q) with bus-over-hw byte merge and pulse self-clear
module mem_reg_cell
  import mem_regs_pkg::*;
#(
  parameter int W = 32,
  parameter int BL = reg_bytes(W),
  parameter reg_mode_e MODE = REG_RW,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic bus_we,
  input  logic [BL-1:0] bus_be,
  input  logic [W-1:0] bus_d,
  input  logic hw_we,
  input  logic [W-1:0] hw_d,
  output logic [W-1:0] q
);
  logic pend;
  logic [W-1:0] bm, base;
  always_comb begin
    bm = '0;
    for (int b = 0; b < W; b++) bm[b] = bus_we && MODE != REG_RO && bus_be[b / 8];
    base = hw_we ? hw_d : pend ? RST_VAL : q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
      pend <= 1'b0;
    end else begin
      q <= (bus_d & bm) | (base & ~bm);
      pend <= MODE == REG_PULSE && bus_we;
    end
  end
endmodule

// File: rtl/mem_reg_bank.sv
// mem_reg_bank: REGISTER_N registers behind a memory-style bus (bus slave modport), hw update ports (reg_hw_din/we), contents reg_q, per-register write/read pulses
module mem_reg_bank
  import mem_regs_pkg::*;
#(
  parameter int REGISTER_N = 16,
  parameter int REG_DATA_WIDTH = 32,
  parameter logic [REGISTER_N-1:0] RO_MASK = '0,
  parameter logic [REGISTER_N-1:0] PULSE_MASK = '0,
  parameter logic [REGISTER_N*REG_DATA_WIDTH-1:0] RESET_VALUES = '0,
  parameter int ADDR_W = (REGISTER_N > 1) ? $clog2(REGISTER_N) : 1
) (
  input  logic clk,
  input  logic rst,
  mem_reg_bank_if.slave bus,
  output logic [REGISTER_N*REG_DATA_WIDTH-1:0] reg_q,
  input  logic [REGISTER_N*REG_DATA_WIDTH-1:0] reg_hw_din,
  input  logic [REGISTER_N-1:0] reg_hw_we,
  output logic [REGISTER_N-1:0] reg_wrPulse,
  output logic [REGISTER_N-1:0] reg_rdPulse
);
  localparam int W = REG_DATA_WIDTH;
  localparam int N = REGISTER_N;
  localparam int BL = reg_bytes(W);
  logic [N-1:0] wsel, rsel, cell_we;
  logic wr_ok, rd_ok;
  logic [W-1:0] rd_d;
  assign wr_ok = bus.mem_wrSelect && |bus.mem_wrByteStrobe;
  assign rd_ok = bus.mem_rdSelect && bus.mem_rdStrobe;
  for (genvar i = 0; i < N; i++) begin : g_reg
    assign wsel[i] = bus.mem_wrAddr == ADDR_W'(i);
    assign rsel[i] = bus.mem_rdAddr == ADDR_W'(i);
    assign cell_we[i] = wr_ok && wsel[i] && !RO_MASK[i];
    mem_reg_cell #(
      .W(W),
      .BL(BL),
      .MODE(reg_mode(RO_MASK[i], PULSE_MASK[i])),
      .RST_VAL(RESET_VALUES[i*W +: W])
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .bus_we(cell_we[i]),
      .bus_be(bus.mem_wrByteStrobe),
      .bus_d(bus.mem_wrdin),
      .hw_we(reg_hw_we[i]),
      .hw_d(reg_hw_din[i*W +: W]),
      .q(reg_q[i*W +: W])
    );
  end
  // an address matching no register leaves rd_d at zero, which is the out-of-range read value
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < N; i++) if (rsel[i]) rd_d = reg_q[i*W +: W];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_rddout <= '0;
      bus.mem_rdValid <= 1'b0;
      bus.mem_rdErr <= 1'b0;
      bus.mem_wrErr <= 1'b0;
      reg_wrPulse <= '0;
      reg_rdPulse <= '0;
    end else begin
      if (rd_ok) bus.mem_rddout <= rd_d;
      bus.mem_rdValid <= rd_ok;
      bus.mem_rdErr <= rd_ok && !(|rsel);
      bus.mem_wrErr <= wr_ok && !(|cell_we);
      reg_wrPulse <= cell_we;
      reg_rdPulse <= rd_ok ? rsel : '0;
    end
  end
endmodule

// File: tb/tb_mem_reg_bank.sv
// tb_mem_reg_bank: directed and random scoreboard bench for mem_reg_bank against an array-based reference model
module tb_mem_reg_bank;
  localparam int N = 16;
  localparam int W = 32;
  localparam int AW = 5;
  localparam int BL = 4;
  localparam logic [N-1:0] RO = 16'h0220;
  localparam logic [N-1:0] PM = 16'h0880;
  function automatic logic [N*W-1:0] mk_rv();
    logic [N*W-1:0] r;
    r = '0;
    r[3*W +: W] = 32'hDEADBEEF;
    r[5*W +: W] = 32'h0000_5A5A;
    r[11*W +: W] = 32'hA5A5_0000;
    return r;
  endfunction
  localparam logic [N*W-1:0] RV = mk_rv();

  logic clk = 1'b0;
  logic rst;
  logic [N*W-1:0] reg_q, reg_hw_din;
  logic [N-1:0] reg_hw_we, reg_wrPulse, reg_rdPulse;
  always #5 clk = ~clk;

  mem_reg_bank_if #(.REGISTER_N(N), .REG_DATA_WIDTH(W), .ADDR_W(AW)) mif ();
  mem_reg_bank #(
    .REGISTER_N(N), .REG_DATA_WIDTH(W), .RO_MASK(RO), .PULSE_MASK(PM), .RESET_VALUES(RV), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .bus(mif), .reg_q(reg_q), .reg_hw_din(reg_hw_din), .reg_hw_we(reg_hw_we),
    .reg_wrPulse(reg_wrPulse), .reg_rdPulse(reg_rdPulse)
  );

  typedef struct packed {logic [W-1:0] d; logic e;} rd_t;
  rd_t q_rd[$];
  logic [W-1:0] m[N];
  logic pend[N];
  logic exp_we, exp_rv;
  logic [N-1:0] exp_wp, exp_rp;
  int total = 0, bad = 0, rd_issued = 0, rd_seen = 0;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] dq(input int i);
    return reg_q[i*W +: W];
  endfunction

  // read monitor: every valid pops the oldest issued read
  always @(negedge clk) begin
    if (mif.mem_rdValid === 1'b1) begin
      rd_seen++;
      if (q_rd.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected got=valid exp=none t=%0t", $time);
      end else begin
        rd_t e;
        e = q_rd.pop_front();
        chk("rd_data", mif.mem_rddout, e.d);
        chk("rd_err", W'(mif.mem_rdErr), W'(e.e));
      end
    end
  end

  task automatic idle();
    mif.mem_wrSelect = 1'b0;
    mif.mem_wrAddr = '0;
    mif.mem_wrdin = '0;
    mif.mem_wrByteStrobe = '0;
    mif.mem_rdSelect = 1'b0;
    mif.mem_rdAddr = '0;
    mif.mem_rdStrobe = 1'b0;
    reg_hw_we = '0;
    reg_hw_din = '0;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d, input logic [BL-1:0] be);
    mif.mem_wrSelect = 1'b1;
    mif.mem_wrAddr = AW'(a);
    mif.mem_wrdin = d;
    mif.mem_wrByteStrobe = be;
  endtask

  task automatic rd(input int a);
    mif.mem_rdSelect = 1'b1;
    mif.mem_rdStrobe = 1'b1;
    mif.mem_rdAddr = AW'(a);
  endtask

  // apply current inputs to the model, clock once, compare the architectural state
  task automatic step();
    logic wr_ok, rd_ok, bw;
    logic [W-1:0] nv;
    int wa, ra;
    wa = int'(mif.mem_wrAddr);
    ra = int'(mif.mem_rdAddr);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m[i] = RV[i*W +: W];
        pend[i] = 1'b0;
      end
      exp_we = 1'b0;
      exp_rv = 1'b0;
      exp_wp = '0;
      exp_rp = '0;
    end else begin
      wr_ok = mif.mem_wrSelect && (mif.mem_wrByteStrobe != 0);
      rd_ok = mif.mem_rdSelect && mif.mem_rdStrobe;
      exp_rv = rd_ok;
      exp_rp = '0;
      exp_wp = '0;
      if (rd_ok) begin
        rd_issued++;
        if (ra < N) begin
          q_rd.push_back(rd_t'{m[ra], 1'b0});
          exp_rp[ra] = 1'b1;
        end else q_rd.push_back(rd_t'{'0, 1'b1});
      end
      exp_we = wr_ok && (wa >= N ? 1'b1 : RO[wa]);
      for (int i = 0; i < N; i++) begin
        bw = wr_ok && wa == i && !RO[i];
        nv = reg_hw_we[i] ? reg_hw_din[i*W +: W] : pend[i] ? RV[i*W +: W] : m[i];
        for (int b = 0; b < BL; b++) if (bw && mif.mem_wrByteStrobe[b]) nv[8*b +: 8] = mif.mem_wrdin[8*b +: 8];
        m[i] = nv;
        pend[i] = bw && PM[i];
        exp_wp[i] = bw;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("reg_q[%0d]", i), dq(i), m[i]);
    chk("wr_err", W'(mif.mem_wrErr), W'(exp_we));
    chk("rd_valid", W'(mif.mem_rdValid), W'(exp_rv));
    chk("wr_pulse", W'(reg_wrPulse), W'(exp_wp));
    chk("rd_pulse", W'(reg_rdPulse), W'(exp_rp));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    chk("rst_reg3", dq(3), 32'hDEADBEEF);
    chk("rst_rddout", mif.mem_rddout, 32'h0);
    rst = 1'b0;
    wr(2, 32'h12345678, 4'b0101);
    step();
    chk("wr_merge", dq(2), 32'h00340078);
    chk("wr_pulse2", W'(reg_wrPulse), 32'h0000_0004);
    idle();
    step();
    chk("wr_pulse_gone", W'(reg_wrPulse), 32'h0);
    rd(2);
    wr(2, 32'hFFFFFFFF, 4'b1111);
    step();
    chk("rd_before_wr", mif.mem_rddout, 32'h00340078);
    chk("wr_after_rd", dq(2), 32'hFFFFFFFF);
    idle();
    wr(5, 32'h11111111, 4'b1111);
    step();
    chk("ro_err", W'(mif.mem_wrErr), 32'h1);
    chk("ro_keep", dq(5), 32'h0000_5A5A);
    wr(17, 32'h22222222, 4'b1111);
    step();
    chk("oor_wr_err", W'(mif.mem_wrErr), 32'h1);
    idle();
    rd(17);
    step();
    chk("oor_rd_err", W'(mif.mem_rdErr), 32'h1);
    chk("oor_rd_data", mif.mem_rddout, 32'h0);
    idle();
    wr(7, 32'h1, 4'b1111);
    step();
    chk("pulse_hold", dq(7), 32'h1);
    idle();
    step();
    chk("pulse_clear", dq(7), 32'h0);
    wr(1, 32'hAAAA_AAAA, 4'b0011);
    reg_hw_we = 16'h0002;
    reg_hw_din[1*W +: W] = 32'h5555_5555;
    step();
    chk("bus_hw_merge", dq(1), 32'h5555AAAA);
    idle();
    rd(4);
    rst = 1'b1;
    step();
    chk("rst_drop_rd", W'(mif.mem_rdValid), 32'h0);
    rst = 1'b0;
    idle();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      mif.mem_wrSelect = $urandom_range(0, 3) != 0;
      mif.mem_wrAddr = AW'($urandom_range(0, 19));
      mif.mem_wrdin = $urandom;
      mif.mem_wrByteStrobe = BL'($urandom);
      mif.mem_rdSelect = $urandom_range(0, 3) != 0;
      mif.mem_rdStrobe = $urandom_range(0, 3) != 0;
      mif.mem_rdAddr = AW'($urandom_range(0, 19));
      for (int i = 0; i < N; i++) begin
        reg_hw_we[i] = $urandom_range(0, 7) == 0;
        reg_hw_din[i*W +: W] = $urandom;
      end
      step();
    end
    rst = 1'b0;
    idle();
    step();
    @(negedge clk);
    @(negedge clk);
    chk("rd_count", W'(rd_seen), W'(rd_issued));
    chk("rd_queue", W'(q_rd.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_reg_bank.md
# mem_reg_bank

Parametrised, registered successor to the combinational memory-to-register demux: holds REGISTER_N registers internally instead of forwarding strobes to external flops. Adds per-register access modes (read-write, read-only hardware status, self-clearing pulse), per-register reset values, a registered read path with valid flag, hardware-side update ports, and out-of-range error reporting. Sits between the AXI4-Lite slave's memory-style interface and the user logic of each Caribou block.

## Interface
- REGISTER_N, 16, number of registers (>=1)
- REG_DATA_WIDTH, 32, register width; byte lanes BL = (REG_DATA_WIDTH+7)/8
- RO_MASK, '0, REGISTER_N bits; bit i=1: register i read-only from bus, value sourced from hardware
- PULSE_MASK, '0, REGISTER_N bits; bit i=1: register i self-clears to reset value one cycle after a bus write
- RESET_VALUES, '0, REGISTER_N*REG_DATA_WIDTH bits; slice i is register i reset value
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- mem_wrSelect  in  1  write request qualifier
- mem_wrAddr  in  max(1,$clog2(REGISTER_N))  write register index
- mem_wrdin  in  REG_DATA_WIDTH  write data
- mem_wrByteStrobe  in  BL  byte enables; write occurs only if nonzero
- mem_rdSelect  in  1  read request qualifier
- mem_rdAddr  in  max(1,$clog2(REGISTER_N))  read register index
- mem_rdStrobe  in  1  read request pulse
- mem_rddout  out  REG_DATA_WIDTH  registered read data
- mem_rdValid  out  1  one-cycle pulse, mem_rddout valid
- mem_rdErr  out  1  with mem_rdValid: address out of range
- mem_wrErr  out  1  one-cycle pulse: write to out-of-range or RO register
- reg_q  out  REGISTER_N*REG_DATA_WIDTH  current register contents
- reg_hw_din  in  REGISTER_N*REG_DATA_WIDTH  hardware update data
- reg_hw_we  in  REGISTER_N  per-register hardware load enable
- reg_wrPulse  out  REGISTER_N  one-cycle pulse after bus write commit
- reg_rdPulse  out  REGISTER_N  one-cycle pulse after bus read of that register

## Operation
- Write accepted when mem_wrSelect && |mem_wrByteStrobe. Address < REGISTER_N and not RO: enabled bytes of register updated at clock edge; reg_wrPulse[addr] next cycle. Otherwise no update, mem_wrErr next cycle.
- RO registers: loaded only by reg_hw_we; unconditionally track reg_hw_din when asserted.
- RW registers: reg_hw_we loads full word from reg_hw_din. Same-cycle bus write and hw load on same register: bus-enabled bytes take bus data, remaining bytes take hw data.
- PULSE registers: after bus write, hold written value exactly one cycle, then return to reset value (unless bus/hw write that cycle, which takes priority).
- Read accepted when mem_rdSelect && mem_rdStrobe. In range: mem_rddout <= register value before any same-cycle write; reg_rdPulse[addr] next cycle. Out of range: mem_rddout <= 0, mem_rdErr=1.
- mem_rddout holds last read value until next accepted read.
- Concurrent read and write (any addresses) both serviced same cycle.
- Reset: all registers to RESET_VALUES; mem_rddout=0, mem_rdValid=0, mem_rdErr=0, mem_wrErr=0, reg_wrPulse=0, reg_rdPulse=0. Reset mid-transaction drops the transaction (no valid, no pulse).

## Timing
- Read latency 1: request at edge N, mem_rdValid/mem_rddout at N+1.
- Write visible on reg_q at N+1; reg_wrPulse/mem_wrErr at N+1.
- Back-to-back reads/writes every cycle, no stalls.
- PULSE register: written at N, value on reg_q N+1 only, reset value at N+2.

## Structure
- Package mem_regs_pkg: function computing BL; reg_mode_e {REG_RW, REG_RO, REG_PULSE} plus function decoding mode from masks.
- Sub-module mem_reg_cell: one register with byte-merge, mode, reset value, hw/bus priority; instantiated REGISTER_N times in a generate loop. Read mux and error logic in top.

## Test plan
- Reset with RESET_VALUES slice 3 = 0xDEADBEEF -> reg_q[3]=0xDEADBEEF, all pulses/valid 0.
- Write 0x12345678 strobe 4'b0101 to reg 2 (reset 0) -> reg_q[2]=0x00340078 next cycle, reg_wrPulse[2] one cycle.
- Read reg 2 and write 0xFFFFFFFF to reg 2 same cycle -> mem_rddout=0x00340078, reg_q[2]=0xFFFFFFFF.
- Write to RO reg 5 and to address 17 with REGISTER_N=16 -> no change, mem_wrErr pulsed each; read address 17 -> rddout 0, rdErr=1.
- PULSE reg 7 written 0x1 -> reg_q[7]=1 for exactly one cycle, then 0.
- Bus write 0xAAAA_AAAA strobe 4'b0011 plus hw load 0x5555_5555 on reg 1 same cycle -> reg_q[1]=0x5555AAAA; assert rst during read request -> no mem_rdValid.
